// File: rtl/fetch_pc_btb_if.sv
// Fetch-frontend bundle: F0 PC out to the predictor, F1 packet out to the
// instruction queue, and retire-update / flush in from the backend.
// The master side is the fetch unit; the slave side is its environment.
interface fetch_pc_btb_if;
    logic [31:0] pc_fetch;
    logic        pc_fetch_valid;
    logic        br_pred;          // 1 = TAKEN, 0 = NOT_TAKEN
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
    logic [31:0] flush_pc;

    modport master (
        output pc_fetch, pc_fetch_valid,
        output out_valid, out_pc, out_pred_taken, out_pred_target,
        input  br_pred, out_ready,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        input  flush, flush_pc
    );

    modport slave (
        input  pc_fetch, pc_fetch_valid,
        input  out_valid, out_pc, out_pred_taken, out_pred_target,
        output br_pred, out_ready,
        output upd_valid, upd_pc, upd_taken, upd_target,
        output flush, flush_pc
    );
endinterface

// File: rtl/fetch_pc_btb.sv
// Two-stage fetch PC generator with a direct-mapped branch target buffer.
// F0 presents pc_fetch to the gshare PHT and the BTB; both return their
// registered read one cycle later, when the same PC sits in F1.
// Optional feature macro: FETCH_BTB_BYPASS_EN forwards a same-cycle BTB
// write at the index being read into the registered read data.
module fetch_pc_btb #(
    parameter int          BTB_IDX_W = 4,
    parameter logic [31:0] RESET_PC  = 32'h1eceb000
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_btb_if.master bus
);
    localparam int   ENTRIES = 1 << BTB_IDX_W;
    localparam int   TAG_W   = 32 - BTB_IDX_W - 2;
    localparam logic TAKEN   = 1'b1;

    // F0 / F1 pipeline state
    logic [31:0] f0_pc_reg;
    logic        f0_valid_reg;
    logic [31:0] f1_pc_reg;
    logic        f1_valid_reg;
    logic        f1_first_reg;     // F1 holds a packet in its first cycle
    logic        hold_taken_reg;   // prediction latched on the first F1 cycle
    logic [31:0] hold_target_reg;

    // BTB storage: valid bits in flops (cleared by reset), tag/target in RAM
    logic [ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]   btb_tag_mem    [ENTRIES];
    logic [31:0]        btb_target_mem [ENTRIES];
    logic               rd_valid_reg;
    logic [TAG_W-1:0]   rd_tag_reg;
    logic [31:0]        rd_target_reg;

    logic [BTB_IDX_W-1:0] rd_idx;
    logic [BTB_IDX_W-1:0] wr_idx;
    logic                 wr_en;
    logic                 live_hit;
    logic                 live_taken;
    logic [31:0]          live_target;
    logic                 sel_taken;
    logic [31:0]          sel_target;
    logic                 stall;
    logic                 accept;
    logic                 redirect;

    // Word-offset bits of the update PC never select anything.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.upd_pc[1:0]};

    // Prediction selection and pipeline control
    always_comb begin
        rd_idx      = f0_pc_reg[BTB_IDX_W+1:2];
        wr_idx      = bus.upd_pc[BTB_IDX_W+1:2];
        wr_en       = bus.upd_valid & bus.upd_taken;
        live_hit    = rd_valid_reg & (rd_tag_reg == f1_pc_reg[31:BTB_IDX_W+2]);
        live_taken  = live_hit & (bus.br_pred == TAKEN);
        live_target = live_taken ? rd_target_reg : f1_pc_reg + 32'd4;
        // Only the first F1 cycle sees read data that belongs to f1_pc;
        // afterwards the BTB/PHT are re-reading F0, so use the latched copy.
        sel_taken   = f1_first_reg ? live_taken  : hold_taken_reg;
        sel_target  = f1_first_reg ? live_target : hold_target_reg;
        stall       = f1_valid_reg & ~bus.out_ready;
        accept      = f1_valid_reg & bus.out_ready & ~bus.flush;
        redirect    = accept & sel_taken;
    end

    assign bus.pc_fetch        = f0_pc_reg;
    assign bus.pc_fetch_valid  = f0_valid_reg;
    assign bus.out_valid       = f1_valid_reg;
    assign bus.out_pc          = f1_pc_reg;
    assign bus.out_pred_taken  = f1_valid_reg & sel_taken;
    assign bus.out_pred_target = f1_valid_reg ? sel_target : 32'd0;

    // F0/F1 advance with priority reset > flush > stall > redirect > advance
    always_ff @(posedge clk) begin
        if (rst) begin
            f0_pc_reg       <= RESET_PC;
            f0_valid_reg    <= 1'b0;
            f1_pc_reg       <= 32'd0;
            f1_valid_reg    <= 1'b0;
            f1_first_reg    <= 1'b0;
            hold_taken_reg  <= 1'b0;
            hold_target_reg <= 32'd0;
        end else if (bus.flush) begin
            f0_pc_reg       <= bus.flush_pc;
            f0_valid_reg    <= 1'b1;
            f1_valid_reg    <= 1'b0;
            f1_first_reg    <= 1'b0;
            hold_taken_reg  <= 1'b0;
            hold_target_reg <= 32'd0;
        end else if (stall) begin
            f1_first_reg <= 1'b0;
            if (f1_first_reg) begin
                hold_taken_reg  <= live_taken;
                hold_target_reg <= live_target;
            end
        end else if (redirect) begin
            // Squash the sequential fetch already in F0: one bubble
            f0_pc_reg    <= sel_target;
            f0_valid_reg <= 1'b1;
            f1_valid_reg <= 1'b0;
            f1_first_reg <= 1'b0;
        end else begin
            f1_pc_reg    <= f0_pc_reg;
            f1_valid_reg <= f0_valid_reg;
            f1_first_reg <= 1'b1;
            // The first valid F0 cycle after reset must still show RESET_PC
            if (f0_valid_reg) begin
                f0_pc_reg <= f0_pc_reg + 32'd4;
            end
            f0_valid_reg <= 1'b1;
        end
    end

    // One flop per BTB valid bit so reset clears the whole table at once
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            logic valid_bit_reg;
            // Set on a taken retire to this index, cleared by reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_bit_reg <= 1'b0;
                end else if (wr_en && (wr_idx == BTB_IDX_W'(gi))) begin
                    valid_bit_reg <= 1'b1;
                end
            end
            assign btb_valid[gi] = valid_bit_reg;
        end
    endgenerate

    // Registered read of the valid bit for pc_fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= btb_valid[rd_idx];
`ifdef FETCH_BTB_BYPASS_EN
            if (wr_en && (wr_idx == rd_idx)) begin
                rd_valid_reg <= 1'b1;
            end
`endif
        end
    end

    // Tag/target RAM: write on taken retire, registered read of pc_fetch entry
    always_ff @(posedge clk) begin
        if (wr_en) begin
            btb_tag_mem[wr_idx]    <= bus.upd_pc[31:BTB_IDX_W+2];
            btb_target_mem[wr_idx] <= bus.upd_target;
        end
        rd_tag_reg    <= btb_tag_mem[rd_idx];
        rd_target_reg <= btb_target_mem[rd_idx];
`ifdef FETCH_BTB_BYPASS_EN
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_tag_reg    <= bus.upd_pc[31:BTB_IDX_W+2];
            rd_target_reg <= bus.upd_target;
        end
`endif
    end
endmodule

// File: tb/tb_fetch_pc_btb.sv
// Bench for fetch_pc_btb: directed scenarios followed by random traffic,
// checked every cycle against a behavioural model of the fetch pipeline and
// BTB, plus an independent packet-stream continuity check.
module tb_fetch_pc_btb;
    localparam int          IW       = 4;
    localparam int          ENTRIES  = 1 << IW;
    localparam int          TAG_LO   = IW + 2;
    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic clk = 1'b0;
    logic rst;
    fetch_pc_btb_if bus_if ();

    fetch_pc_btb #(.BTB_IDX_W(IW), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int total;
    int bad;

    // Model state
    logic [31:0] m_f0_pc;
    logic        m_f0_v;
    logic [31:0] m_f1_pc;
    logic        m_f1_v;
    logic        m_first;
    logic        m_snap_hit;
    logic [31:0] m_snap_tgt;
    logic        m_hold_taken;
    logic [31:0] m_hold_tgt;
    logic        m_bv   [ENTRIES];
    logic [31:0] m_bpc  [ENTRIES];
    logic [31:0] m_btgt [ENTRIES];
    logic [31:0] stream_next;

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[IW+1:2]);
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = 32'h1eceb000 + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 7) == 0) p = p + 32'h00010000;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_f0_pc      = RESET_PC;
        m_f0_v       = 1'b0;
        m_f1_pc      = 32'd0;
        m_f1_v       = 1'b0;
        m_first      = 1'b0;
        m_snap_hit   = 1'b0;
        m_snap_tgt   = 32'd0;
        m_hold_taken = 1'b0;
        m_hold_tgt   = 32'd0;
        for (int i = 0; i < ENTRIES; i++) begin
            m_bv[i]   = 1'b0;
            m_bpc[i]  = 32'd0;
            m_btgt[i] = 32'd0;
        end
        stream_next = RESET_PC;
    endtask

    // One clock cycle with the currently driven inputs: compare, then step model.
    task automatic step();
        logic        e_taken;
        logic [31:0] e_tgt;
        logic        acc;
        logic        stl;
        logic        wr;
        logic        s_hit;
        logic [31:0] s_tgt;
        int          ri;
        int          wi;
        #1;
        if (m_f1_v && m_first) begin
            e_taken = m_snap_hit && bus_if.br_pred;
            e_tgt   = e_taken ? m_snap_tgt : m_f1_pc + 32'd4;
        end else if (m_f1_v) begin
            e_taken = m_hold_taken;
            e_tgt   = m_hold_tgt;
        end else begin
            e_taken = 1'b0;
            e_tgt   = 32'd0;
        end
        chk("pc_fetch", bus_if.pc_fetch, m_f0_pc);
        chk("pc_fetch_valid", 32'(bus_if.pc_fetch_valid), 32'(m_f0_v));
        chk("out_valid", 32'(bus_if.out_valid), 32'(m_f1_v));
        chk("out_pred_taken", 32'(bus_if.out_pred_taken), 32'(e_taken));
        if (m_f1_v) begin
            chk("out_pc", bus_if.out_pc, m_f1_pc);
            chk("out_pred_target", bus_if.out_pred_target, e_tgt);
        end

        acc = m_f1_v && bus_if.out_ready && !bus_if.flush;
        stl = m_f1_v && !bus_if.out_ready;
        if (!rst && acc) begin
            chk("stream_pc", bus_if.out_pc, stream_next);
            stream_next = e_tgt;
        end

        if (rst) begin
            model_reset();
        end else begin
            wr    = bus_if.upd_valid && bus_if.upd_taken;
            ri    = idx(m_f0_pc);
            s_hit = m_bv[ri] && ((m_bpc[ri] >> TAG_LO) == (m_f0_pc >> TAG_LO));
            s_tgt = m_btgt[ri];
`ifdef FETCH_BTB_BYPASS_EN
            if (wr && idx(bus_if.upd_pc) == ri) begin
                s_hit = ((bus_if.upd_pc >> TAG_LO) == (m_f0_pc >> TAG_LO));
                s_tgt = bus_if.upd_target;
            end
`endif
            if (bus_if.flush) begin
                m_f0_pc      = bus_if.flush_pc;
                m_f0_v       = 1'b1;
                m_f1_v       = 1'b0;
                m_first      = 1'b0;
                m_hold_taken = 1'b0;
                m_hold_tgt   = 32'd0;
                stream_next  = bus_if.flush_pc;
            end else if (stl) begin
                if (m_first) begin
                    m_hold_taken = e_taken;
                    m_hold_tgt   = e_tgt;
                end
                m_first = 1'b0;
            end else if (acc && e_taken) begin
                m_f0_pc = e_tgt;
                m_f0_v  = 1'b1;
                m_f1_v  = 1'b0;
                m_first = 1'b0;
            end else begin
                m_f1_pc    = m_f0_pc;
                m_f1_v     = m_f0_v;
                m_first    = 1'b1;
                m_snap_hit = s_hit;
                m_snap_tgt = s_tgt;
                if (m_f0_v) m_f0_pc = m_f0_pc + 32'd4;
                m_f0_v = 1'b1;
            end
            if (wr) begin
                wi         = idx(bus_if.upd_pc);
                m_bv[wi]   = 1'b1;
                m_bpc[wi]  = bus_if.upd_pc;
                m_btgt[wi] = bus_if.upd_target;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_pkt(input logic [31:0] pc);
        int n;
        n = 0;
        while (!(bus_if.out_valid && bus_if.out_pc == pc) && n < 64) begin
            step();
            n++;
        end
        total++;
        assert (n < 64) else begin
            bad++;
            $error("FAIL wait_pkt observed=timeout expected=packet pc %h", pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_if.br_pred    = 1'b0;
        bus_if.out_ready  = 1'b1;
        bus_if.upd_valid  = 1'b0;
        bus_if.upd_pc     = 32'd0;
        bus_if.upd_taken  = 1'b0;
        bus_if.upd_target = 32'd0;
        bus_if.flush      = 1'b0;
        bus_if.flush_pc   = 32'd0;
        model_reset();
        @(negedge clk);
        step();
        step();
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_pc_fetch", bus_if.pc_fetch, 32'h1eceb000);
        chk("rst_pc_fetch_valid", 32'(bus_if.pc_fetch_valid), 32'd0);
        chk("rst_pred_taken", 32'(bus_if.out_pred_taken), 32'd0);
        chk("rst_pred_target", bus_if.out_pred_target, 32'd0);

        // Reset release plus a BTB entry for 1eceb010 -> 1eceb100
        rst = 1'b0;
        bus_if.br_pred    = 1'b1;
        bus_if.upd_valid  = 1'b1;
        bus_if.upd_taken  = 1'b1;
        bus_if.upd_pc     = 32'h1eceb010;
        bus_if.upd_target = 32'h1eceb100;
        step();
        bus_if.upd_valid = 1'b0;
        chk("s1_pc_fetch_c1", bus_if.pc_fetch, 32'h1eceb000);
        chk("s1_pc_valid_c1", 32'(bus_if.pc_fetch_valid), 32'd1);
        chk("s1_out_valid_c1", 32'(bus_if.out_valid), 32'd0);
        step();
        chk("s1_out_valid_c2", 32'(bus_if.out_valid), 32'd1);
        chk("s1_out_pc_c2", bus_if.out_pc, 32'h1eceb000);
        chk("s1_pred_taken_c2", 32'(bus_if.out_pred_taken), 32'd0);
        chk("s1_pc_fetch_c2", bus_if.pc_fetch, 32'h1eceb004);
        step();
        chk("s1_out_pc_c3", bus_if.out_pc, 32'h1eceb004);
        chk("s1_pc_fetch_c3", bus_if.pc_fetch, 32'h1eceb008);

        // Taken hit redirect with one bubble
        wait_pkt(32'h1eceb010);
        chk("s2_taken", 32'(bus_if.out_pred_taken), 32'd1);
        chk("s2_target", bus_if.out_pred_target, 32'h1eceb100);
        step();
        chk("s2_bubble", 32'(bus_if.out_valid), 32'd0);
        step();
        chk("s2_after_valid", 32'(bus_if.out_valid), 32'd1);
        chk("s2_after_pc", bus_if.out_pc, 32'h1eceb100);

        // Same hit, predictor says not taken: sequential, no bubble
        bus_if.flush = 1'b1;
        bus_if.flush_pc = 32'h1eceb010;
        step();
        bus_if.flush = 1'b0;
        bus_if.br_pred = 1'b0;
        chk("s3_pc_fetch", bus_if.pc_fetch, 32'h1eceb010);
        chk("s3_f1_squashed", 32'(bus_if.out_valid), 32'd0);
        step();
        chk("s3_out_pc", bus_if.out_pc, 32'h1eceb010);
        chk("s3_taken", 32'(bus_if.out_pred_taken), 32'd0);
        chk("s3_target", bus_if.out_pred_target, 32'h1eceb014);
        step();
        chk("s3_no_bubble", 32'(bus_if.out_valid), 32'd1);
        chk("s3_next_pc", bus_if.out_pc, 32'h1eceb014);

        // Five-cycle stall on a taken hit while br_pred toggles
        bus_if.flush = 1'b1;
        bus_if.flush_pc = 32'h1eceb010;
        step();
        bus_if.flush = 1'b0;
        bus_if.br_pred = 1'b1;
        step();
        chk("s4_first_taken", 32'(bus_if.out_pred_taken), 32'd1);
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            bus_if.br_pred = k[0];
            #1;
            chk("s4_hold_valid", 32'(bus_if.out_valid), 32'd1);
            chk("s4_hold_pc", bus_if.out_pc, 32'h1eceb010);
            chk("s4_hold_taken", 32'(bus_if.out_pred_taken), 32'd1);
            chk("s4_hold_target", bus_if.out_pred_target, 32'h1eceb100);
        end
        bus_if.out_ready = 1'b1;
        step();
        chk("s4_bubble", 32'(bus_if.out_valid), 32'd0);
        step();
        chk("s4_redir_pc", bus_if.out_pc, 32'h1eceb100);
        step();
        chk("s4_once_pc", bus_if.out_pc, 32'h1eceb104);

        // Flush during a stalled taken hit
        bus_if.br_pred = 1'b1;
        bus_if.flush = 1'b1;
        bus_if.flush_pc = 32'h1eceb010;
        step();
        bus_if.flush = 1'b0;
        step();
        bus_if.out_ready = 1'b0;
        step();
        bus_if.flush = 1'b1;
        bus_if.flush_pc = 32'h1eceb200;
        step();
        bus_if.flush = 1'b0;
        bus_if.out_ready = 1'b1;
        chk("s5a_pc_fetch", bus_if.pc_fetch, 32'h1eceb200);
        chk("s5a_f1_invalid", 32'(bus_if.out_valid), 32'd0);

        // Flush in the same cycle as an accepted taken redirect
        bus_if.flush = 1'b1;
        bus_if.flush_pc = 32'h1eceb010;
        step();
        bus_if.flush = 1'b0;
        step();
        bus_if.flush = 1'b1;
        bus_if.flush_pc = 32'h1eceb200;
        step();
        bus_if.flush = 1'b0;
        chk("s5b_pc_fetch", bus_if.pc_fetch, 32'h1eceb200);
        chk("s5b_f1_invalid", 32'(bus_if.out_valid), 32'd0);
        step();
        chk("s5b_out_pc", bus_if.out_pc, 32'h1eceb200);

        // BTB write to the index being read in the same cycle
        bus_if.flush = 1'b1;
        bus_if.flush_pc = 32'h1eceb300;
        step();
        bus_if.flush = 1'b0;
        bus_if.upd_valid  = 1'b1;
        bus_if.upd_taken  = 1'b1;
        bus_if.upd_pc     = 32'h1eceb300;
        bus_if.upd_target = 32'h1eceb3c0;
        step();
        bus_if.upd_valid = 1'b0;
        chk("s6_out_pc", bus_if.out_pc, 32'h1eceb300);
`ifdef FETCH_BTB_BYPASS_EN
        chk("s6_same_cycle_taken", 32'(bus_if.out_pred_taken), 32'd1);
`else
        chk("s6_same_cycle_taken", 32'(bus_if.out_pred_taken), 32'd0);
`endif
        step();
        bus_if.flush = 1'b1;
        bus_if.flush_pc = 32'h1eceb300;
        step();
        bus_if.flush = 1'b0;
        step();
        chk("s6_refetch_taken", 32'(bus_if.out_pred_taken), 32'd1);
        chk("s6_refetch_target", bus_if.out_pred_target, 32'h1eceb3c0);

        // Reset in the middle of a stall clears pipeline and BTB
        bus_if.out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        chk("s6_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("s6_rst_pc_fetch", bus_if.pc_fetch, RESET_PC);
        chk("s6_rst_pc_valid", 32'(bus_if.pc_fetch_valid), 32'd0);
        wait_pkt(32'h1eceb010);
        chk("s6_rst_btb_cleared", 32'(bus_if.out_pred_taken), 32'd0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            bus_if.out_ready  = ($urandom_range(0, 3) != 0);
            bus_if.br_pred    = 1'($urandom_range(0, 1));
            bus_if.upd_valid  = ($urandom_range(0, 2) == 0);
            bus_if.upd_taken  = ($urandom_range(0, 3) != 0);
            bus_if.upd_pc     = rand_pc();
            bus_if.upd_target = rand_pc();
            bus_if.flush      = ($urandom_range(0, 39) == 0);
            bus_if.flush_pc   = rand_pc();
            rst               = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        bus_if.flush = 1'b0;
        bus_if.upd_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
